ex_muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the forwarded Read1_E/Read2_E operands and a decoded mul/div opcode, and holds the architectural HI/LO registers. It drives a busy flag that the hazard unit uses to stall the D stage on mul/div/mfhi/mflo instructions.

---
 rtl/ex_muldiv_unit_pkg.sv | 31 +++
 rtl/ex_muldiv_unit_md_arith.sv | 47 ++++
 rtl/ex_muldiv_unit.sv | 93 +++++++++
 tb/tb_ex_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared mul/div definitions: md_op encoding (also used by decoder and hazard unit),
// sequencer state encoding and default latencies.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } mdOp_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } mdState_e;

  localparam int DefMultCycles = 5;
  localparam int DefDivCycles  = 10;

  function automatic logic isMultOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_md_arith.sv
// Combinational result generator for mult/multu/div/divu: {HI, LO} packed into 64 bits,
// plus a zero-divisor flag so the sequencer can suppress the HI/LO write.
module ex_muldiv_unit_md_arith
  import ex_muldiv_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic [63:0] result,
  output logic        divZero
);

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic        signedDiv;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] quotU;
  logic [31:0] remU;
  logic [31:0] quotS;
  logic [31:0] remS;

  assign prodU = {32'd0, srcA} * {32'd0, srcB};
  assign prodS = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign divZero   = (srcB == 32'd0);
  assign signedDiv = (op == MD_DIV);
  assign magA      = (signedDiv && srcA[31]) ? (32'd0 - srcA) : srcA;
  assign magB      = (signedDiv && srcB[31]) ? (32'd0 - srcB) : srcB;
  assign quotU     = divZero ? 32'd0 : (magA / magB);
  assign remU      = divZero ? 32'd0 : (magA % magB);
  assign quotS     = (srcA[31] ^ srcB[31]) ? (32'd0 - quotU) : quotU;
  assign remS      = srcA[31] ? (32'd0 - remU) : remU;

  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prodS;
      MD_MULTU: result = prodU;
      MD_DIV:   result = {remS, quotS};
      MD_DIVU:  result = {remU, quotU};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle mul/div sequencer owning the architectural HI/LO registers.
// The result is computed at the start edge and held as pending until the final busy cycle.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DefMultCycles,
  parameter int DIV_CYCLES  = DefDivCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  mdState_e    state_q;
  logic [31:0] cnt_q;
  logic [31:0] pendHi_q;
  logic [31:0] pendLo_q;
  logic        pendZero_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0] arithResult;
  logic        arithDivZero;

  ex_muldiv_unit_md_arith uArith (
    .op      (md_op),
    .srcA    (src_a),
    .srcB    (src_b),
    .result  (arithResult),
    .divZero (arithDivZero)
  );

  // A start seen while RUN is dropped entirely; the hazard unit is expected to prevent it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MD_IDLE;
      cnt_q      <= 32'd0;
      pendHi_q   <= 32'd0;
      pendLo_q   <= 32'd0;
      pendZero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            if (isMultOp(md_op) || isDivOp(md_op)) begin
              pendHi_q   <= arithResult[63:32];
              pendLo_q   <= arithResult[31:0];
              pendZero_q <= isDivOp(md_op) && arithDivZero;
              cnt_q      <= isMultOp(md_op) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
              state_q    <= MD_RUN;
            end else if (md_op == MD_MTHI) begin
              hi_q <= src_a;
            end else if (md_op == MD_MTLO) begin
              lo_q <= src_a;
            end
          end
        end
        MD_RUN: begin
          if (cnt_q == 32'd1) begin
            if (!pendZero_q) begin
              hi_q <= pendHi_q;
              lo_q <= pendLo_q;
            end
            cnt_q   <= 32'd0;
            state_q <= MD_IDLE;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    if (reset && start && (state_q == MD_RUN)) begin
      assert (1'b0) else $warning("ex_muldiv_unit: start asserted while busy, request dropped");
    end
  end

  assign busy   = (state_q == MD_RUN);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops
// compared against an arithmetic HI/LO model.
module tb_ex_muldiv_unit;

  localparam int MultCycles = 5;
  localparam int DivCycles  = 10;

  localparam logic [2:0] OpNone  = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(
    .MULT_CYCLES (MultCycles),
    .DIV_CYCLES  (DivCycles)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int expCycles(input logic [2:0] op);
    if (op == OpMult || op == OpMultu) return MultCycles;
    if (op == OpDiv || op == OpDivu) return DivCycles;
    return 0;
  endfunction

  // Architectural effect of one accepted op on HI/LO, from plain 64-bit arithmetic.
  task automatic refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint          sq;
    longint          sr;
    longint unsigned up;
    case (op)
      OpMult: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        modelHi = sp[63:32];
        modelLo = sp[31:0];
      end
      OpMultu: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        modelHi = up[63:32];
        modelLo = up[31:0];
      end
      OpDiv: begin
        if (b != 32'd0) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          modelLo = sq[31:0];
          modelHi = sr[31:0];
        end
      end
      OpDivu: begin
        if (b != 32'd0) begin
          modelLo = a / b;
          modelHi = a % b;
        end
      end
      OpMthi: modelHi = a;
      OpMtlo: modelLo = a;
      default: ;
    endcase
  endtask

  // Issues one op for a single edge, then counts busy cycles and watches HI/LO stay put.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int cycles, output bit stable);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    md_op = OpNone;
    cycles = 0;
    stable = 1'b1;
    while (busy === 1'b1 && cycles < 100) begin
      if (hi_out !== modelHi || lo_out !== modelLo) stable = 1'b0;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    bit stable;
    applyStimulus(op, a, b, n, stable);
    refModel(op, a, b);
    checkOutput({tag, " busyCycles"}, 32'(n), 32'(expCycles(op)));
    checkOutput({tag, " stable"}, 32'(stable), 32'd1);
    checkOutput({tag, " hi"}, hi_out, modelHi);
    checkOutput({tag, " lo"}, lo_out, modelLo);
  endtask

  initial begin
    int          n;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b0;
    start = 1'b0;
    md_op = OpNone;
    src_a = 32'd0;
    src_b = 32'd0;
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset hi", hi_out, 32'd0);
    checkOutput("reset lo", lo_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    runOp("mthi", OpMthi, 32'h11, 32'h0);
    runOp("mtlo", OpMtlo, 32'h22, 32'h0);
    runOp("divu by zero", OpDivu, 32'd1234, 32'd0);
    checkOutput("divzero keeps hi", hi_out, 32'h11);
    checkOutput("divzero keeps lo", lo_out, 32'h22);
    runOp("div by zero", OpDiv, 32'hFFFF_FF00, 32'd0);

    runOp("mult -3*5", OpMult, 32'hFFFF_FFFD, 32'd5);
    checkOutput("mult -3*5 const hi", hi_out, 32'hFFFF_FFFF);
    checkOutput("mult -3*5 const lo", lo_out, 32'hFFFF_FFF1);
    runOp("multu max*max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multu const hi", hi_out, 32'hFFFF_FFFE);
    checkOutput("multu const lo", lo_out, 32'h0000_0001);
    runOp("div -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div -7/2 const lo", lo_out, 32'hFFFF_FFFD);
    checkOutput("div -7/2 const hi", hi_out, 32'hFFFF_FFFF);
    runOp("divu 7/2", OpDivu, 32'd7, 32'd2);
    runOp("div min/-1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div min/-1 const lo", lo_out, 32'h8000_0000);
    checkOutput("div min/-1 const hi", hi_out, 32'h0);
    runOp("none", OpNone, 32'hDEAD_BEEF, 32'd3);
    runOp("undef7", 3'd7, 32'hDEAD_BEEF, 32'd3);

    // Second start while RUN must be dropped: MULT 4*4 finishes on its own schedule.
    @(negedge clk);
    start = 1'b1;
    md_op = OpMult;
    src_a = 32'd4;
    src_b = 32'd4;
    @(negedge clk);
    n = 0;
    md_op = OpDivu;
    src_a = 32'd9;
    src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    md_op = OpNone;
    if (busy === 1'b1) n = 1;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    n++;
    checkOutput("ignored start busyCycles", 32'(n), 32'(MultCycles));
    checkOutput("ignored start lo", lo_out, 32'd16);
    checkOutput("ignored start hi", hi_out, 32'd0);
    modelHi = 32'd0;
    modelLo = 32'd16;

    // Asynchronous reset in the middle of a multiply.
    runOp("mthi pre-reset", OpMthi, 32'hABCD, 32'h0);
    @(negedge clk);
    start = 1'b1;
    md_op = OpMult;
    src_a = 32'd2;
    src_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    md_op = OpNone;
    @(negedge clk);
    checkOutput("midrun busy before reset", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset hi", hi_out, 32'd0);
    checkOutput("async reset lo", lo_out, 32'd0);
    modelHi = 32'd0;
    modelLo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    runOp("mult 2*3 after reset", OpMult, 32'd2, 32'd3);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        ra = 32'($urandom_range(0, 200)) - 32'd100;
        rb = 32'($urandom_range(0, 20)) - 32'd10;
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
